// File: rtl/dac_frame_sequencer.sv
// Standalone main_state/channel sequencer for DAC_modified.
// It buffers amplifier samples, loads one per frame into the target slot, and captures the HPF result.
module dac_frame_sequencer #(
    parameter int NUM_CHANNELS = 20,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [5:0]  target_channel,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [31:0] main_state,
    output logic [5:0]  channel,
    output logic [15:0] DAC_input,
    input  logic [15:0] DAC_register,
    output logic [15:0] result_out,
    output logic        result_valid,
    output logic [15:0] underrun_count,
    output logic        running
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [5:0] LAST_CH = 6'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {PARK, S99, S100, S135, S170, S205} state_t;

    state_t        state, state_next;
    logic [5:0]    channel_next;
    logic [5:0]    target_q;
    logic          target_ok;
    logic          slot_match;
    logic          load_slot;
    logic          capture_slot;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty, fifo_full;
    logic          do_push, do_pop;

    function automatic logic [31:0] state_code(input state_t s);
        case (s)
            S100:    return 32'd100;
            S135:    return 32'd135;
            S170:    return 32'd170;
            S205:    return 32'd205;
            default: return 32'd99;
        endcase
    endfunction

    always_comb begin
        state_next   = state;
        channel_next = channel;
        case (state)
            PARK: begin
                if (enable) begin
                    state_next   = S99;
                    channel_next = 6'd0;
                end
            end
            S99:  state_next = S100;
            S100: state_next = S135;
            S135: state_next = S170;
            S170: state_next = S205;
            S205: begin
                if (channel != LAST_CH) begin
                    channel_next = channel + 6'd1;
                    state_next   = S99;
                end else begin
                    channel_next = 6'd0;
                    state_next   = enable ? S99 : PARK;
                end
            end
            default: begin
                state_next   = PARK;
                channel_next = 6'd0;
            end
        endcase
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            state      <= PARK;
            channel    <= 6'd0;
            main_state <= 32'd99;
            running    <= 1'b0;
        end else begin
            state      <= state_next;
            channel    <= channel_next;
            main_state <= state_code(state_next);
            running    <= (state_next != PARK);
        end
    end

    // Target is frozen at the start of channel 0 so one frame never mixes two targets.
    always_ff @(posedge dataclk) begin
        if (reset)
            target_q <= 6'h3F;
        else if (state == S99 && channel == 6'd0)
            target_q <= target_channel;
    end

    assign target_ok    = ({1'b0, target_q} < 7'(NUM_CHANNELS));
    assign slot_match   = target_ok && (channel == target_q);
    assign load_slot    = (state == S100) && slot_match;
    assign capture_slot = (state == S170) && slot_match;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign sample_ready = !fifo_full;
    assign do_push      = sample_valid && !fifo_full;
    assign do_pop       = load_slot && !fifo_empty;

    always_ff @(posedge dataclk) begin
        if (do_push)
            mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // An empty FIFO at the load slot leaves the DAC on its previous sample.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            DAC_input      <= 16'd0;
            underrun_count <= 16'd0;
            result_out     <= 16'd0;
            result_valid   <= 1'b0;
        end else begin
            if (do_pop)
                DAC_input <= mem[rd_ptr];
            if (load_slot && fifo_empty && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
            if (capture_slot)
                result_out <= DAC_register;
            result_valid <= capture_slot;
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Self-checking bench for dac_frame_sequencer: expected samples and results are queued by the bench
// when driven and compared when the sequencer loads or captures them.
module tb_dac_frame_sequencer;

    logic        dataclk = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  target_channel;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic [15:0] DAC_input;
    logic [15:0] DAC_register;
    logic [15:0] result_out;
    logic        result_valid;
    logic [15:0] underrun_count;
    logic        running;

    int pass_count  = 0;
    int check_count = 0;

    logic [15:0] exp_dac [$];
    logic [15:0] exp_res [$];
    int unsigned codes [5] = '{99, 100, 135, 170, 205};

    dac_frame_sequencer #(.NUM_CHANNELS(20), .FIFO_DEPTH(16)) dut (
        .dataclk(dataclk),
        .reset(reset),
        .enable(enable),
        .target_channel(target_channel),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .main_state(main_state),
        .channel(channel),
        .DAC_input(DAC_input),
        .DAC_register(DAC_register),
        .result_out(result_out),
        .result_valid(result_valid),
        .underrun_count(underrun_count),
        .running(running)
    );

    always #5 dataclk = ~dataclk;

    task automatic step();
        @(negedge dataclk);
    endtask

    function automatic logic [15:0] pop_dac();
        if (exp_dac.size() == 0)
            return 16'hxxxx;
        return exp_dac.pop_front();
    endfunction

    function automatic logic [15:0] pop_res();
        if (exp_res.size() == 0)
            return 16'hxxxx;
        return exp_res.pop_front();
    endfunction

    task automatic do_reset();
        step();
        reset          = 1'b1;
        enable         = 1'b0;
        sample_valid   = 1'b0;
        sample_in      = 16'd0;
        target_channel = 6'd0;
        DAC_register   = 16'd0;
        step();
        step();
        reset = 1'b0;
        exp_dac.delete();
        exp_res.delete();
    endtask

    // Called at a falling edge; the word is taken on the following rising edge if ready was high.
    task automatic push_sample(input logic [15:0] v, output bit accepted);
        sample_in    = v;
        sample_valid = 1'b1;
        accepted     = sample_ready;
        if (accepted)
            exp_dac.push_back(v);
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        check_count++;
        if ({main_state, channel, running} !== {32'd99, 6'd0, 1'b0})
            $display("[TB] FAIL reset_state: got ms=%0d ch=%0d run=%b expected ms=99 ch=0 run=0",
                     main_state, channel, running);
        else pass_count++;
        check_count++;
        if ({DAC_input, result_out, result_valid} !== {16'h0, 16'h0, 1'b0})
            $display("[TB] FAIL reset_data: got dac=%h res=%h rv=%b expected 0000 0000 0",
                     DAC_input, result_out, result_valid);
        else pass_count++;
        check_count++;
        if ({underrun_count, sample_ready} !== {16'h0, 1'b1})
            $display("[TB] FAIL reset_fifo: got underrun=%0d ready=%b expected 0 1",
                     underrun_count, sample_ready);
        else pass_count++;
    endtask

    task automatic test_frame_sequence();
        bit acc;
        int errs;
        logic [15:0] exp;
        do_reset();
        push_sample(16'h1234, acc);
        check_count++;
        if (acc !== 1'b1)
            $display("[TB] FAIL seq_push_accept: got %b expected 1", acc);
        else pass_count++;
        target_channel = 6'd0;
        enable = 1'b1;
        step();
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            if (main_state !== 32'(codes[k % 5]) || channel !== 6'(k / 5) || running !== 1'b1)
                errs++;
            if (k == 1) begin
                check_count++;
                if (DAC_input !== 16'h0000)
                    $display("[TB] FAIL seq_dac_before_load: got %h expected 0000", DAC_input);
                else pass_count++;
            end
            if (k == 2) begin
                exp = pop_dac();
                check_count++;
                if (DAC_input !== exp || main_state !== 32'd135)
                    $display("[TB] FAIL seq_dac_load: got dac=%h ms=%0d expected dac=%h ms=135",
                             DAC_input, main_state, exp);
                else pass_count++;
            end
            step();
        end
        check_count++;
        if (errs != 0)
            $display("[TB] FAIL seq_frame_order: got %0d bad cycles expected 0", errs);
        else pass_count++;
        check_count++;
        if ({main_state, channel, running} !== {32'd99, 6'd0, 1'b1})
            $display("[TB] FAIL seq_frame_length: got ms=%0d ch=%0d run=%b expected ms=99 ch=0 run=1",
                     main_state, channel, running);
        else pass_count++;
    endtask

    task automatic test_capture();
        int strobes;
        logic [15:0] exp;
        do_reset();
        DAC_register   = 16'h0BEE;
        target_channel = 6'd5;
        enable         = 1'b1;
        step();
        for (int f = 0; f < 2; f++) begin
            strobes = 0;
            for (int k = 0; k < 100; k++) begin
                if (k == 0) begin
                    if (f == 1)
                        DAC_register = 16'h0C0D;
                    exp_res.push_back(DAC_register);
                end
                if (result_valid === 1'b1) begin
                    strobes++;
                    exp = pop_res();
                    check_count++;
                    if ({main_state, channel, result_out} !== {32'd205, 6'd5, exp})
                        $display("[TB] FAIL cap_slot: got ms=%0d ch=%0d res=%h expected ms=205 ch=5 res=%h",
                                 main_state, channel, result_out, exp);
                    else pass_count++;
                end
                step();
            end
            check_count++;
            if (strobes != 1)
                $display("[TB] FAIL cap_strobes_per_frame: got %0d expected 1", strobes);
            else pass_count++;
        end
    endtask

    task automatic test_underrun();
        bit acc;
        logic [15:0] last_dac;
        do_reset();
        push_sample(16'hA5A5, acc);
        target_channel = 6'd0;
        enable = 1'b1;
        step();
        last_dac = 16'hxxxx;
        for (int k = 0; k <= 800; k++) begin
            if (k == 2) begin
                last_dac = pop_dac();
                check_count++;
                if (DAC_input !== last_dac)
                    $display("[TB] FAIL und_first_load: got %h expected %h", DAC_input, last_dac);
                else pass_count++;
            end
            if (k == 400) begin
                check_count++;
                if (underrun_count !== 16'd3)
                    $display("[TB] FAIL und_count3: got %0d expected 3", underrun_count);
                else pass_count++;
                check_count++;
                if (DAC_input !== last_dac)
                    $display("[TB] FAIL und_dac_hold: got %h expected %h", DAC_input, last_dac);
                else pass_count++;
                force dut.underrun_count = 16'hFFFD;
            end
            if (k == 401)
                release dut.underrun_count;
            if (k == 410) begin
                check_count++;
                if (underrun_count !== 16'hFFFE)
                    $display("[TB] FAIL und_preload_inc: got %h expected fffe", underrun_count);
                else pass_count++;
            end
            if (k == 510) begin
                check_count++;
                if (underrun_count !== 16'hFFFF)
                    $display("[TB] FAIL und_reach_max: got %h expected ffff", underrun_count);
                else pass_count++;
            end
            if (k == 800) begin
                check_count++;
                if (underrun_count !== 16'hFFFF)
                    $display("[TB] FAIL und_saturate: got %h expected ffff", underrun_count);
                else pass_count++;
            end
            step();
        end
    endtask

    task automatic test_fifo_full();
        bit acc;
        int rejects;
        logic [15:0] exp;
        do_reset();
        rejects = 0;
        for (int i = 0; i < 16; i++) begin
            push_sample(16'(i), acc);
            if (!acc)
                rejects++;
        end
        check_count++;
        if (rejects != 0)
            $display("[TB] FAIL full_accept16: got %0d rejected expected 0", rejects);
        else pass_count++;
        check_count++;
        if (sample_ready !== 1'b0)
            $display("[TB] FAIL full_ready_low: got %b expected 0", sample_ready);
        else pass_count++;
        push_sample(16'h00EE, acc);
        check_count++;
        if (acc !== 1'b0)
            $display("[TB] FAIL full_17th_ignored: got accepted=%b expected 0", acc);
        else pass_count++;
        target_channel = 6'd0;
        enable = 1'b1;
        step();
        for (int k = 0; k <= 1602; k++) begin
            if (k % 100 == 2 && k < 1600) begin
                exp = pop_dac();
                check_count++;
                if (DAC_input !== exp)
                    $display("[TB] FAIL full_order frame %0d: got %h expected %h", k / 100, DAC_input, exp);
                else pass_count++;
            end
            if (k == 1600) begin
                check_count++;
                if (sample_ready !== 1'b1)
                    $display("[TB] FAIL full_ready_back: got %b expected 1", sample_ready);
                else pass_count++;
            end
            if (k == 1602) begin
                check_count++;
                if ({DAC_input, underrun_count} !== {16'h000F, 16'd1})
                    $display("[TB] FAIL full_drained: got dac=%h underrun=%0d expected dac=000f underrun=1",
                             DAC_input, underrun_count);
                else pass_count++;
            end
            step();
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        target_channel = 6'h3F;
        enable = 1'b1;
        step();
        for (int k = 0; k < 99; k++) begin
            if (k == 42)
                enable = 1'b0;
            step();
        end
        check_count++;
        if ({main_state, channel, running} !== {32'd205, 6'd19, 1'b1})
            $display("[TB] FAIL drop_frame_completes: got ms=%0d ch=%0d run=%b expected ms=205 ch=19 run=1",
                     main_state, channel, running);
        else pass_count++;
        step();
        check_count++;
        if ({main_state, channel, running} !== {32'd99, 6'd0, 1'b0})
            $display("[TB] FAIL drop_parked: got ms=%0d ch=%0d run=%b expected ms=99 ch=0 run=0",
                     main_state, channel, running);
        else pass_count++;
        step();
        step();
        step();
        check_count++;
        if ({main_state, channel, running, underrun_count} !== {32'd99, 6'd0, 1'b0, 16'd0})
            $display("[TB] FAIL drop_stays_parked: got ms=%0d ch=%0d run=%b und=%0d expected 99 0 0 0",
                     main_state, channel, running, underrun_count);
        else pass_count++;
        enable = 1'b1;
        step();
        check_count++;
        if ({main_state, channel, running} !== {32'd99, 6'd0, 1'b1})
            $display("[TB] FAIL drop_reenable_s99: got ms=%0d ch=%0d run=%b expected ms=99 ch=0 run=1",
                     main_state, channel, running);
        else pass_count++;
        step();
        check_count++;
        if ({main_state, channel} !== {32'd100, 6'd0})
            $display("[TB] FAIL drop_reenable_s100: got ms=%0d ch=%0d expected ms=100 ch=0",
                     main_state, channel);
        else pass_count++;
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        logic [15:0] exp;
        do_reset();
        push_sample(16'hBEEF, acc);
        push_sample(16'h1111, acc);
        DAC_register   = 16'h7777;
        target_channel = 6'd7;
        enable = 1'b1;
        step();
        for (int k = 0; k < 37; k++)
            step();
        exp = pop_dac();
        check_count++;
        if ({main_state, channel, DAC_input} !== {32'd135, 6'd7, exp})
            $display("[TB] FAIL rst_pre_state: got ms=%0d ch=%0d dac=%h expected ms=135 ch=7 dac=%h",
                     main_state, channel, DAC_input, exp);
        else pass_count++;
        reset = 1'b1;
        step();
        check_count++;
        if ({main_state, channel, DAC_input, result_valid, running, underrun_count} !==
            {32'd99, 6'd0, 16'h0, 1'b0, 1'b0, 16'h0})
            $display("[TB] FAIL rst_mid_frame: got ms=%0d ch=%0d dac=%h rv=%b run=%b und=%0d expected 99 0 0000 0 0 0",
                     main_state, channel, DAC_input, result_valid, running, underrun_count);
        else pass_count++;
        reset = 1'b0;
        exp_dac.delete();
        target_channel = 6'd0;
        step();
        check_count++;
        if ({result_valid, running} !== {1'b0, 1'b1})
            $display("[TB] FAIL rst_restart: got rv=%b run=%b expected rv=0 run=1", result_valid, running);
        else pass_count++;
        step();
        step();
        check_count++;
        if ({DAC_input, underrun_count} !== {16'h0, 16'd1})
            $display("[TB] FAIL rst_fifo_flushed: got dac=%h und=%0d expected dac=0000 und=1",
                     DAC_input, underrun_count);
        else pass_count++;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        target_channel = 6'd0;
        sample_in      = 16'd0;
        sample_valid   = 1'b0;
        DAC_register   = 16'd0;
        test_reset();
        test_frame_sequence();
        test_capture();
        test_underrun();
        test_fifo_full();
        test_enable_drop();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
